// File: rtl/vdp_io_port.sv
// rtl/vdp_io_port.sv - Z80 I/O front end of the VDP: port decode, command protocol, VRAM/CRAM/mode regs
// Optional VDP_STATUS_READ_EN: control-port reads return a vblank status register.
module vdp_io_port #(
   parameter int SYNC_STAGES = 2,
   parameter int VRAM_AW     = 14
) (
   input  logic               clk_100,
   input  logic               rst,
   inout  wire  [7:0]         data_bus,
   input  logic [7:0]         addr_bus,
   input  logic               IORQ_L,
   input  logic               RD_L,
   input  logic               WR_L,
   output logic               BUSY,
   input  logic [VRAM_AW-1:0] vram_rd_addr,
   output logic [7:0]         vram_rd_data
`ifdef VDP_STATUS_READ_EN
   ,
   input  logic               vblank_pulse
`endif
);

   localparam int SW = $clog2(SYNC_STAGES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DONE, S_WAIT, S_LOAD} state_t;

   state_t               state_q, state_d;
   logic [VRAM_AW-1:0]   addr_q, addr_d;
   logic [1:0]           code_q, code_d;
   logic                 latch_q, latch_d;
   logic [7:0]           cmd_lo_q, cmd_lo_d;
   logic [7:0]           buffer_q, buffer_d;
   logic [7:0]           rd_val_q, rd_val_d;
   logic [SYNC_STAGES-1:0] iorq_sync_q, iorq_sync_d;
   logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
   logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
   logic [SW-1:0]        settle_q, settle_d;
   logic                 wr_prev_q, wr_prev_d;
   logic                 rd_prev_q, rd_prev_d;

   logic [7:0]           regs_q [16];
   logic [7:0]           cram_q [32];
   logic [7:0]           vram_mem [1 << VRAM_AW];
   logic [7:0]           z_rd_q;
   logic [7:0]           rr_data_q;

   logic                 sel, settled, wr_n, rd_n, wr_ev, rd_ev;
   logic [7:0]           data_in, rd_src;
   logic                 vram_we, cram_we, reg_we;
   logic                 unused_fold;

   assign sel     = (addr_bus[7:6] == 2'b10);
   assign data_in = data_bus;
   assign settled = (settle_q == SW'(SYNC_STAGES));
   assign wr_n    = iorq_sync_q[SYNC_STAGES-1] | wr_sync_q[SYNC_STAGES-1];
   assign rd_n    = iorq_sync_q[SYNC_STAGES-1] | rd_sync_q[SYNC_STAGES-1];
   // Edges only count once the pipeline holds post-reset samples, so a strobe held across reset is ignored
   assign wr_ev   = settled & wr_prev_q & ~wr_n;
   assign rd_ev   = settled & rd_prev_q & ~rd_n;

`ifdef VDP_STATUS_READ_EN
   logic status_q;
   logic stat_clr;
   assign rd_src = addr_bus[0] ? {status_q, 7'b0} : buffer_q;
`else
   assign rd_src = addr_bus[0] ? 8'h00 : buffer_q;
`endif

   assign data_bus     = (!IORQ_L && !RD_L && sel) ? rd_val_q : 8'hzz;
   assign BUSY         = (state_q != S_IDLE);
   assign vram_rd_data = rr_data_q;

   always_comb begin
      iorq_sync_d = {iorq_sync_q[SYNC_STAGES-2:0], IORQ_L};
      rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], RD_L};
      wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], WR_L};
      settle_d    = settled ? settle_q : settle_q + SW'(1);
      wr_prev_d   = settled ? wr_n : 1'b0;
      rd_prev_d   = settled ? rd_n : 1'b0;
      // Hold the value on the bus steady for the whole read strobe, even while the buffer refills
      rd_val_d    = rd_n ? rd_src : rd_val_q;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      code_d   = code_q;
      latch_d  = latch_q;
      cmd_lo_d = cmd_lo_q;
      buffer_d = buffer_q;
      vram_we  = 1'b0;
      cram_we  = 1'b0;
      reg_we   = 1'b0;
`ifdef VDP_STATUS_READ_EN
      stat_clr = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (wr_ev && sel) begin
               if (addr_bus[0]) begin
                  if (!latch_q) begin
                     cmd_lo_d = data_in;
                     latch_d  = 1'b1;
                     state_d  = S_DONE;
                  end else begin
                     latch_d = 1'b0;
                     code_d  = data_in[7:6];
                     if (data_in[7:6] == 2'b10) begin
                        reg_we  = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        addr_d  = VRAM_AW'({data_in[5:0], cmd_lo_q});
                        state_d = (data_in[7:6] == 2'b00) ? S_WAIT : S_DONE;
                     end
                  end
               end else begin
                  latch_d  = 1'b0;
                  cram_we  = (code_q == 2'b11);
                  vram_we  = (code_q != 2'b11);
                  buffer_d = data_in;
                  addr_d   = addr_q + VRAM_AW'(1);
                  state_d  = S_DONE;
               end
            end else if (rd_ev && sel) begin
               if (!addr_bus[0]) begin
                  latch_d = 1'b0;
                  state_d = S_WAIT;
               end else begin
`ifdef VDP_STATUS_READ_EN
                  latch_d  = 1'b0;
                  stat_clr = 1'b1;
`endif
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         // z_rd_q follows addr_q with one clock of latency, so the refill lands one state later
         S_WAIT: state_d = S_LOAD;
         S_LOAD: begin
            buffer_d = z_rd_q;
            addr_d   = addr_q + VRAM_AW'(1);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_100) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         code_q      <= 2'b00;
         latch_q     <= 1'b0;
         cmd_lo_q    <= 8'h00;
         buffer_q    <= 8'h00;
         rd_val_q    <= 8'h00;
         iorq_sync_q <= '1;
         rd_sync_q   <= '1;
         wr_sync_q   <= '1;
         settle_q    <= '0;
         wr_prev_q   <= 1'b0;
         rd_prev_q   <= 1'b0;
         for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
         for (int i = 0; i < 32; i++) cram_q[i] <= 8'h00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         code_q      <= code_d;
         latch_q     <= latch_d;
         cmd_lo_q    <= cmd_lo_d;
         buffer_q    <= buffer_d;
         rd_val_q    <= rd_val_d;
         iorq_sync_q <= iorq_sync_d;
         rd_sync_q   <= rd_sync_d;
         wr_sync_q   <= wr_sync_d;
         settle_q    <= settle_d;
         wr_prev_q   <= wr_prev_d;
         rd_prev_q   <= rd_prev_d;
         if (reg_we)  regs_q[data_in[3:0]] <= cmd_lo_q;
         if (cram_we) cram_q[addr_q[4:0]]  <= data_in;
      end
   end

   // True dual-port VRAM: contents survive reset; a same-address collision reads old data
   always_ff @(posedge clk_100) begin
      if (vram_we && !rst) vram_mem[addr_q] <= data_in;
      z_rd_q    <= vram_mem[addr_q];
      rr_data_q <= vram_mem[vram_rd_addr];
   end

`ifdef VDP_STATUS_READ_EN
   always_ff @(posedge clk_100) begin
      if (rst)               status_q <= 1'b0;
      else if (vblank_pulse) status_q <= 1'b1;
      else if (stat_clr)     status_q <= 1'b0;
   end
`endif

   always_comb begin
      unused_fold = ^addr_bus[5:1];
      for (int i = 0; i < 16; i++) unused_fold = unused_fold ^ (^regs_q[i]);
      for (int i = 0; i < 32; i++) unused_fold = unused_fold ^ (^cram_q[i]);
   end

endmodule

// File: tb/tb_vdp_io_port.sv
// tb/tb_vdp_io_port.sv - self-checking bench for vdp_io_port: vector table, reset corner, random vs model
module tb_vdp_io_port;

   logic        clk_100 = 1'b0;
   logic        rst;
   logic [7:0]  addr_bus;
   logic        IORQ_L, RD_L, WR_L;
   logic        BUSY;
   logic [13:0] vram_rd_addr;
   logic [7:0]  vram_rd_data;
   wire  [7:0]  data_bus;
   logic        drv_en;
   logic [7:0]  drv_val;
`ifdef VDP_STATUS_READ_EN
   logic        vblank_pulse = 1'b0;
`endif

   always #5 clk_100 = ~clk_100;

   assign data_bus = drv_en ? drv_val : 8'hzz;
   for (genvar gi = 0; gi < 8; gi++) begin : g_pu
      pullup (data_bus[gi]);
   end

   vdp_io_port dut (
      .clk_100      (clk_100),
      .rst          (rst),
      .data_bus     (data_bus),
      .addr_bus     (addr_bus),
      .IORQ_L       (IORQ_L),
      .RD_L         (RD_L),
      .WR_L         (WR_L),
      .BUSY         (BUSY),
      .vram_rd_addr (vram_rd_addr),
      .vram_rd_data (vram_rd_data)
`ifdef VDP_STATUS_READ_EN
      ,
      .vblank_pulse (vblank_pulse)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;
   int busy_cnt = 0;

   always @(negedge clk_100) if (BUSY === 1'b1) busy_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic acc(input logic [7:0] port, input bit wr, input logic [7:0] v,
                      output logic [7:0] early, output logic [7:0] late, output int busy);
      int b0;
      addr_bus = port;
      if (wr) begin
         drv_val = v;
         drv_en  = 1'b1;
      end
      @(negedge clk_100);
      b0 = busy_cnt;
      IORQ_L = 1'b0;
      if (wr) WR_L = 1'b0;
      else    RD_L = 1'b0;
      repeat (2) @(negedge clk_100);
      early = data_bus;
      repeat (6) @(negedge clk_100);
      late = data_bus;
      IORQ_L = 1'b1;
      WR_L   = 1'b1;
      RD_L   = 1'b1;
      repeat (2) @(negedge clk_100);
      drv_en = 1'b0;
      repeat (3) @(negedge clk_100);
      busy = busy_cnt - b0;
      addr_bus = 8'h00;
   endtask

   task automatic vr(input logic [13:0] a, output logic [7:0] d);
      vram_rd_addr = a;
      @(negedge clk_100);
      d = vram_rd_data;
   endtask

   function automatic logic [7:0] cport();
      return {2'b10, 5'($urandom), 1'b1};
   endfunction
   function automatic logic [7:0] dport();
      return {2'b10, 5'($urandom), 1'b0};
   endfunction

   typedef enum {OP_CW, OP_DW, OP_DR, OP_CR, OP_XW, OP_XR, OP_VR, OP_AD, OP_RG, OP_CM, OP_BF} op_t;
   typedef struct {
      op_t         op;
      logic [15:0] arg;
      logic [7:0]  val;
      int          busy;
   } vec_t;
   vec_t tv[$];

   // Reference model of the programmer-visible state
   bit [7:0] m_vram [16384];
   bit       m_kn   [16384];
   bit [7:0] m_regs [16];
   bit [7:0] m_cram [32];
   int       m_addr, m_code;
   bit       m_latch, m_bk;
   bit [7:0] m_cmd_lo, m_buf;

   task automatic m_ctrl(input logic [7:0] b);
      if (!m_latch) begin
         m_cmd_lo = b;
         m_latch  = 1'b1;
      end else begin
         m_latch = 1'b0;
         m_code  = int'(b[7:6]);
         if (m_code == 2) m_regs[b[3:0]] = m_cmd_lo;
         else begin
            m_addr = int'({b[5:0], m_cmd_lo});
            if (m_code == 0) begin
               m_buf  = m_vram[m_addr];
               m_bk   = m_kn[m_addr];
               m_addr = (m_addr + 1) % 16384;
            end
         end
      end
   endtask

   task automatic m_dwrite(input logic [7:0] d);
      m_latch = 1'b0;
      if (m_code == 3) m_cram[m_addr % 32] = d;
      else begin
         m_vram[m_addr] = d;
         m_kn[m_addr]   = 1'b1;
      end
      m_buf  = d;
      m_bk   = 1'b1;
      m_addr = (m_addr + 1) % 16384;
   endtask

   task automatic m_dread();
      m_latch = 1'b0;
      m_buf   = m_vram[m_addr];
      m_bk    = m_kn[m_addr];
      m_addr  = (m_addr + 1) % 16384;
   endtask

   logic [7:0] e, l, rv, port, b8, hi, lo;
   int         b, b0, k;

   initial begin
      rst = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1;
      addr_bus = 8'h00; drv_en = 1'b0; drv_val = 8'h00; vram_rd_addr = '0;
      repeat (4) @(negedge clk_100);
      rst = 1'b0;
      repeat (4) @(negedge clk_100);
      chk("reset_busy", BUSY, 1'b0);
      chk("reset_bus_hiz", data_bus, 8'hFF);

      tv.push_back('{OP_AD, 16'h0000, 8'h00, -1});
      tv.push_back('{OP_BF, 16'h0000, 8'h00, -1});
      tv.push_back('{OP_RG, 16'h0007, 8'h00, -1});
      tv.push_back('{OP_CM, 16'h001F, 8'h00, -1});
      tv.push_back('{OP_CR, 16'h0000, 8'h00, -1});
      tv.push_back('{OP_XW, 16'h007E, 8'h12,  0});
      tv.push_back('{OP_XR, 16'h00FE, 8'hFF,  0});
      tv.push_back('{OP_AD, 16'h0000, 8'h00, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'hCE,  1});
      tv.push_back('{OP_CW, 16'h0000, 8'h4A,  1});
      tv.push_back('{OP_DW, 16'h0000, 8'h55,  1});
      tv.push_back('{OP_DW, 16'h0000, 8'h77,  1});
      tv.push_back('{OP_DW, 16'h0000, 8'h99,  1});
      tv.push_back('{OP_VR, 16'h0ACE, 8'h55, -1});
      tv.push_back('{OP_VR, 16'h0ACF, 8'h77, -1});
      tv.push_back('{OP_VR, 16'h0AD0, 8'h99, -1});
      tv.push_back('{OP_AD, 16'h0AD1, 8'h00, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'hCF,  1});
      tv.push_back('{OP_CW, 16'h0000, 8'h0A,  2});
      tv.push_back('{OP_DR, 16'h0000, 8'h77,  2});
      tv.push_back('{OP_BF, 16'h0000, 8'h99, -1});
      tv.push_back('{OP_AD, 16'h0AD1, 8'h00, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'h3C,  1});
      tv.push_back('{OP_CW, 16'h0000, 8'h87,  1});
      tv.push_back('{OP_RG, 16'h0007, 8'h3C, -1});
      tv.push_back('{OP_AD, 16'h0AD1, 8'h00, -1});
      tv.push_back('{OP_VR, 16'h0ACE, 8'h55, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'h1F,  1});
      tv.push_back('{OP_CW, 16'h0000, 8'hC0,  1});
      tv.push_back('{OP_DW, 16'h0000, 8'h2A,  1});
      tv.push_back('{OP_DW, 16'h0000, 8'h15,  1});
      tv.push_back('{OP_CM, 16'h001F, 8'h2A, -1});
      tv.push_back('{OP_CM, 16'h0000, 8'h15, -1});
      tv.push_back('{OP_AD, 16'h0021, 8'h00, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'hFF, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'h7F, -1});
      tv.push_back('{OP_DW, 16'h0000, 8'hAA, -1});
      tv.push_back('{OP_DW, 16'h0000, 8'hBB, -1});
      tv.push_back('{OP_VR, 16'h3FFF, 8'hAA, -1});
      tv.push_back('{OP_VR, 16'h0000, 8'hBB, -1});
      tv.push_back('{OP_AD, 16'h0001, 8'h00, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'hCE, -1});
      tv.push_back('{OP_DR, 16'h0000, 8'hBB,  2});
      tv.push_back('{OP_CW, 16'h0000, 8'h00, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'h00,  2});
      tv.push_back('{OP_AD, 16'h0001, 8'h00, -1});
      tv.push_back('{OP_BF, 16'h0000, 8'hBB, -1});
      tv.push_back('{OP_DR, 16'h0000, 8'hBB, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'h00, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'h42, -1});
      tv.push_back('{OP_DW, 16'h0000, 8'h5A, -1});
      tv.push_back('{OP_VR, 16'h0200, 8'h5A, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'h00, -1});
      tv.push_back('{OP_CW, 16'h0000, 8'h42, -1});

      foreach (tv[i]) begin
         case (tv[i].op)
            OP_CW, OP_DW, OP_XW: begin
               port = (tv[i].op == OP_CW) ? cport() : (tv[i].op == OP_DW) ? dport() : tv[i].arg[7:0];
               acc(port, 1'b1, tv[i].val, e, l, b);
               if (tv[i].busy >= 0) chk($sformatf("busy_w[%0d]", i), b, tv[i].busy);
            end
            OP_DR, OP_CR, OP_XR: begin
               port = (tv[i].op == OP_CR) ? cport() : (tv[i].op == OP_DR) ? dport() : tv[i].arg[7:0];
               acc(port, 1'b0, 8'h00, e, l, b);
               chk($sformatf("rd_early[%0d]", i), e, tv[i].val);
               chk($sformatf("rd_late[%0d]", i), l, tv[i].val);
               if (tv[i].busy >= 0) chk($sformatf("busy_r[%0d]", i), b, tv[i].busy);
            end
            OP_VR: begin
               vr(tv[i].arg[13:0], rv);
               chk($sformatf("vram[%h]", tv[i].arg), rv, tv[i].val);
            end
            OP_AD: chk($sformatf("addr[%0d]", i), 32'(dut.addr_q), 32'(tv[i].arg));
            OP_RG: chk($sformatf("reg[%0d]", tv[i].arg), dut.regs_q[tv[i].arg[3:0]], tv[i].val);
            OP_CM: chk($sformatf("cram[%0d]", tv[i].arg), dut.cram_q[tv[i].arg[4:0]], tv[i].val);
            OP_BF: chk($sformatf("buffer[%0d]", i), dut.buffer_q, tv[i].val);
            default: ;
         endcase
      end

      // Reset lands while a write strobe is low; the strobe stays low after reset drops
      addr_bus = dport();
      drv_val  = 8'hEE;
      drv_en   = 1'b1;
      @(negedge clk_100);
      IORQ_L = 1'b0;
      WR_L   = 1'b0;
      @(negedge clk_100);
      rst = 1'b1;
      repeat (3) @(negedge clk_100);
      rst = 1'b0;
      b0 = busy_cnt;
      repeat (12) @(negedge clk_100);
      IORQ_L = 1'b1;
      WR_L   = 1'b1;
      repeat (4) @(negedge clk_100);
      chk("rst_strobe_busy", busy_cnt - b0, 0);
      drv_en = 1'b0;
      @(negedge clk_100);
      chk("rst_bus_hiz", data_bus, 8'hFF);
      vr(14'h0200, rv);
      chk("rst_no_write_0200", rv, 8'h5A);
      vr(14'h0000, rv);
      chk("rst_no_write_0000", rv, 8'hBB);
      chk("rst_addr", 32'(dut.addr_q), 32'h0);
      acc(dport(), 1'b0, 8'h00, e, l, b);
      chk("rst_buffer_read", l, 8'h00);

      // Randomized traffic against the model
      rst = 1'b1;
      repeat (3) @(negedge clk_100);
      rst = 1'b0;
      repeat (4) @(negedge clk_100);
      for (int i = 0; i < 16384; i++) m_kn[i] = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      for (int i = 0; i < 32; i++) m_cram[i] = 8'h00;
      m_addr = 0; m_code = 0; m_latch = 1'b0; m_cmd_lo = 8'h00; m_buf = 8'h00; m_bk = 1'b1;

      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 9);
         if (k < 3) begin
            lo = 8'($urandom_range(0, 31));
            hi = {2'($urandom), 6'h10};
            if (hi[7:6] == 2'b10) hi[3:0] = 4'($urandom);
            acc(cport(), 1'b1, lo, e, l, b);
            m_ctrl(lo);
            acc(cport(), 1'b1, hi, e, l, b);
            m_ctrl(hi);
         end else if (k == 3) begin
            b8 = 8'($urandom);
            acc(cport(), 1'b1, b8, e, l, b);
            m_ctrl(b8);
         end else if (k < 7) begin
            b8 = 8'($urandom);
            acc(dport(), 1'b1, b8, e, l, b);
            m_dwrite(b8);
         end else begin
            acc(dport(), 1'b0, 8'h00, e, l, b);
            if (m_bk) begin
               chk($sformatf("rnd_rd_early[%0d]", n), e, m_buf);
               chk($sformatf("rnd_rd_late[%0d]", n), l, m_buf);
            end
            m_dread();
         end
      end

      chk("rnd_addr", 32'(dut.addr_q), 32'(m_addr));
      for (int i = 0; i < 16; i++) chk($sformatf("rnd_reg[%0d]", i), dut.regs_q[i], m_regs[i]);
      for (int i = 0; i < 32; i++) chk($sformatf("rnd_cram[%0d]", i), dut.cram_q[i], m_cram[i]);
      for (int a = 16'h1000; a < 16'h1020; a++) begin
         if (m_kn[a]) begin
            vr(14'(a), rv);
            chk($sformatf("rnd_vram[%h]", a), rv, m_vram[a]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vdp_io_port.md
Name: vdp_io_port

Overview:
- Z80-facing I/O front end of the video display processor (VDP).
- Decodes Z80 IN/OUT cycles to the VDP data port (0xBE) and control port (0xBF). Runs the two-byte command protocol, the 14-bit auto-incrementing address register and the read-ahead buffer.
- Owns the 16 KiB VRAM, 32-byte CRAM and 16 mode registers.
- Provides a read-only VRAM port for the renderer.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the Z80 strobe synchronizers (minimum 2).
- VRAM_AW, 14: VRAM address width; depth is 2^VRAM_AW bytes.

Ports:
- clk_100 input 1: the only clock, 100 MHz; all logic on its rising edge.
- rst input 1: synchronous, active-high reset.
- data_bus inout 8: Z80 data bus; driven only during a VDP read cycle, otherwise high-Z.
- addr_bus input 8: Z80 address bits [7:0] (port number).
- IORQ_L input 1: Z80 I/O request, active low, asynchronous to clk_100.
- RD_L input 1: Z80 read strobe, active low, asynchronous.
- WR_L input 1: Z80 write strobe, active low, asynchronous.
- BUSY output 1: high while an accepted port access is still being processed internally.
- vram_rd_addr input VRAM_AW: renderer VRAM read address.
- vram_rd_data output 8: renderer read data; equals VRAM[vram_rd_addr] one clock later.

Behaviour:
- Port decode: selected when addr_bus[7:6]==2'b10. addr_bus[0]=0 selects the data port; addr_bus[0]=1 selects the control port. No other address bits are decoded.
- Strobe synchronization: IORQ_L, RD_L and WR_L each pass through SYNC_STAGES flip-flops.
  - A write event is the first synchronized clock where IORQ_L=0 and WR_L=0, detected as a falling edge of (IORQ_L|WR_L). addr_bus and data_bus are sampled in that same clock.
  - A read event is the same edge detection on (IORQ_L|RD_L).
  - Exactly one event per strobe assertion, however long the strobe is held.
- data_bus drive: combinational on raw inputs. When IORQ_L=0 and RD_L=0 and the port is selected, drive the registered read value; otherwise high-Z.
- Control-port write: uses a 1-bit latch (first/second byte).
  - First byte: store it in cmd_lo and set the latch.
  - Second byte (value b): code=b[7:6], addr = {b[5:0], cmd_lo}, then clear the latch.
    - code 00: one clock later, buffer = VRAM[addr] and addr = addr+1.
    - code 01: VRAM write mode.
    - code 10: reg[b[3:0]] = cmd_lo.
    - code 11: CRAM write mode.
- Data-port write (value d): clears the latch.
  - code 11: CRAM[addr[4:0]] = d.
  - Any other code: VRAM[addr] = d.
  - In all cases buffer = d and addr = addr+1.
- Data-port read: the bus shows the current buffer; the latch is cleared. After the event: buffer = VRAM[addr], addr = addr+1.
- Address arithmetic: addr wraps 0x3FFF -> 0x0000. CRAM index uses addr[4:0] only.
- BUSY: rises the clock after any event is detected. It falls once the memory operation and buffer refill complete, at most 2 clocks later; control writes that touch no memory take 1 clock.
- Simultaneous events: a write event and a read event in the same clock is impossible on a legal Z80 bus. If it occurs, the write takes priority and the read is dropped.
- Renderer port: independent of the Z80 side. VRAM is true dual-port and the renderer port is never stalled. Same-address collision returns the old data.
- Reset values:
  - addr = 0, code = 00, latch = 0, cmd_lo = 0, buffer = 0.
  - All 16 regs = 0, all 32 CRAM bytes = 0, BUSY = 0.
  - Synchronizer flip-flops reset to 1 (strobes idle high).
  - VRAM contents are not reset.
- Reset mid-cycle: a pending operation is abandoned. A strobe still low when rst drops produces no event; a new falling edge is required.

Optional Feature:
- Macro VDP_STATUS_READ_EN.
- Defined: a control-port read returns an 8-bit status register and clears the latch.
  - Status bit 7 (frame flag) is set by an added input vblank_pulse (1 bit).
  - Bits 6:0 read as 0.
  - The whole register clears on the status read.
- Undefined: control-port reads drive 0x00 with no side effects, and vblank_pulse is absent.

Test Plan:
- VRAM write burst: control CE, 4A, then data 55, 77, 99 -> VRAM[0x0ACE]=55, [0x0ACF]=77, [0x0AD0]=99; addr=0x0AD1.
- Read setup and read: after the burst, control CF, 0A, then data-port read -> data_bus=77 during RD_L low; afterwards buffer=99 and addr=0x0AD1.
- Register write: control 3C, 87 -> reg[7]=0x3C; addr and VRAM unchanged.
- CRAM write with wrap: control 1F, C0, then data 2A, 15 -> CRAM[31]=2A, CRAM[0]=15 (addr[4:0] wraps).
- Address wrap: control FF, 7F, then data AA, BB -> VRAM[0x3FFF]=AA, VRAM[0x0000]=BB.
- Latch reset and reset behaviour: control CE, then data-port read, then control 00, 00 -> address/code come from the last two bytes (00, 00); rst mid-strobe -> no write, BUSY=0, data_bus high-Z.
